// File: rtl/btn_event_sched_pkg.sv
// Shared types and helpers for the push-button event scheduler.
package btn_event_sched_pkg;

  // Arbiter states: waiting for a pending press, or holding an offer.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  // Width of a button index; never narrower than one bit.
  function automatic int btn_id_w(input int n_btn);
    if (n_btn > 1) begin
      return $clog2(n_btn);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/btn_event_sched_if.sv
// Button/event bundle between the scheduler and its consumer.
// The scheduler side is the master: it produces events and status flags.
interface btn_event_sched_if
  import btn_event_sched_pkg::*;
#(
  parameter int N_BTN = 4
);
  localparam int ID_W = btn_id_w(N_BTN);

  logic [N_BTN-1:0] btn_in;
  logic             evt_valid;
  logic             evt_ready;
  logic [ID_W-1:0]  evt_id;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] overflow;
  logic             ovf_clr;
  logic             tick;

  modport master (
    input  btn_in, evt_ready, ovf_clr,
    output evt_valid, evt_id, pending, overflow, tick
  );

  modport slave (
    output btn_in, evt_ready, ovf_clr,
    input  evt_valid, evt_id, pending, overflow, tick
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, tick-qualified stable counter,
// debounced level and a single-cycle press pulse on a 0->1 change.
module btn_debounce_ch #(
  parameter int STABLE_SAMPLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic press
);
  localparam int SC_W = $clog2(STABLE_SAMPLES + 1);

  logic            sync1_r;
  logic            sync2_r;
  logic            state_r;
  logic            press_r;
  logic [SC_W-1:0] cnt_r;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // On each tick, accept a new level only after it has held for STABLE_SAMPLES ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= 1'b0;
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (tick) begin
        if (sync2_r == state_r) begin
          cnt_r <= '0;
        end else if (cnt_r == SC_W'(STABLE_SAMPLES - 1)) begin
          // This tick is the STABLE_SAMPLES-th differing sample.
          state_r <= sync2_r;
          cnt_r   <= '0;
          press_r <= sync2_r;
        end else begin
          cnt_r <= cnt_r + SC_W'(1'b1);
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/btn_event_sched.sv
// Push-button front end: sample-tick generator, N debounced channels,
// per-button pending/overflow flags and a round-robin valid/ready arbiter.
module btn_event_sched
  import btn_event_sched_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int TICK_DIV       = 1000000,
  parameter int STABLE_SAMPLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  btn_event_sched_if.master bus
);
  localparam int ID_W  = btn_id_w(N_BTN);
  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] tick_cnt_r;
  logic             tick_r;
  logic [N_BTN-1:0] press_s;

  arb_state_t       state_r;
  logic             evt_valid_r;
  logic [ID_W-1:0]  evt_id_r;
  logic [ID_W-1:0]  ptr_r;
  logic [N_BTN-1:0] pending_r;
  logic [N_BTN-1:0] overflow_r;

  logic             grant_s;
  logic [N_BTN-1:0] grant_vec_s;
  logic [N_BTN-1:0] pending_nxt_s;
  logic [N_BTN-1:0] overflow_nxt_s;
  logic [ID_W-1:0]  pick_s;
  logic             pick_found_s;
  logic [ID_W-1:0]  ptr_inc_s;

  // Free-running divider; tick is registered so it is high while the count is TICK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= '0;
      tick_r     <= 1'b0;
    end else begin
      if (tick_cnt_r == CNT_W'(TICK_DIV - 1)) begin
        tick_cnt_r <= '0;
      end else begin
        tick_cnt_r <= tick_cnt_r + CNT_W'(1'b1);
      end
      tick_r <= (tick_cnt_r == CNT_W'(TICK_DIV - 2));
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick_r),
      .btn_raw (bus.btn_in[gi]),
      .press   (press_s[gi])
    );
  end

  // Decode the handshake into a one-hot grant vector.
  always_comb begin
    grant_s     = (state_r == ST_OFFER) && evt_valid_r && bus.evt_ready;
    grant_vec_s = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (grant_s && (evt_id_r == ID_W'(i))) begin
        grant_vec_s[i] = 1'b1;
      end else begin
        grant_vec_s[i] = 1'b0;
      end
    end
  end

  // Next pending/overflow flags: a press beats a grant, a new overflow beats ovf_clr.
  always_comb begin
    pending_nxt_s  = pending_r;
    overflow_nxt_s = overflow_r;
    for (int i = 0; i < N_BTN; i++) begin
      if (press_s[i]) begin
        pending_nxt_s[i] = 1'b1;
        if (pending_r[i] && !grant_vec_s[i]) begin
          overflow_nxt_s[i] = 1'b1;
        end else if (bus.ovf_clr) begin
          overflow_nxt_s[i] = 1'b0;
        end else begin
          overflow_nxt_s[i] = overflow_r[i];
        end
      end else begin
        if (grant_vec_s[i]) begin
          pending_nxt_s[i] = 1'b0;
        end else begin
          pending_nxt_s[i] = pending_r[i];
        end
        if (bus.ovf_clr) begin
          overflow_nxt_s[i] = 1'b0;
        end else begin
          overflow_nxt_s[i] = overflow_r[i];
        end
      end
    end
  end

  // Round-robin search: first pending bit at or above ptr, wrapping.
  always_comb begin
    int idx;
    idx          = 0;
    pick_s       = ptr_r;
    pick_found_s = 1'b0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= N_BTN) begin
        idx = idx - N_BTN;
      end else begin
        idx = idx;
      end
      if (!pick_found_s && pending_r[idx]) begin
        pick_s       = ID_W'(idx);
        pick_found_s = 1'b1;
      end else begin
        pick_s       = pick_s;
        pick_found_s = pick_found_s;
      end
    end
  end

  // Pointer moves just past the granted id, wrapping at N_BTN.
  always_comb begin
    if (evt_id_r == ID_W'(N_BTN - 1)) begin
      ptr_inc_s = '0;
    end else begin
      ptr_inc_s = evt_id_r + ID_W'(1'b1);
    end
  end

  // Arbiter FSM plus flag registers; an offer is held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      evt_valid_r <= 1'b0;
      evt_id_r    <= '0;
      ptr_r       <= '0;
      pending_r   <= '0;
      overflow_r  <= '0;
    end else begin
      pending_r  <= pending_nxt_s;
      overflow_r <= overflow_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            evt_id_r    <= pick_s;
            evt_valid_r <= 1'b1;
            state_r     <= ST_OFFER;
          end else begin
            evt_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        ST_OFFER: begin
          if (bus.evt_ready) begin
            ptr_r       <= ptr_inc_s;
            evt_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            evt_valid_r <= 1'b1;
            state_r     <= ST_OFFER;
          end
        end
        default: begin
          evt_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tick      = tick_r;
  assign bus.evt_valid = evt_valid_r;
  assign bus.evt_id    = evt_id_r;
  assign bus.pending   = pending_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: doc/btn_event_sched.md
Name: btn_event_sched

Overview:
Front-end controller for the board push-buttons. It generates its own sample tick and debounces N raw button inputs. Each button's press is turned into a single event, and a round-robin arbiter presents those events one at a time to the downstream command/FSM logic over a valid/ready handshake. It replaces the per-button slow-clock debounce instances, so the whole button path runs on the single system clock.

Parameters:
N_BTN, 4, number of button channels (2..8)
TICK_DIV, 1000000, clk cycles per sample tick (10 ms at 100 MHz); must be >= 2
STABLE_SAMPLES, 2, consecutive ticks a new level must hold before the debounced state changes; must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_in  in  N_BTN  raw, asynchronous button levels, active-high
evt_valid  out  1  an event is offered
evt_ready  in  1  consumer accepts the event
evt_id  out  clog2(N_BTN)  index of the offered button
pending  out  N_BTN  per-button press-waiting flags
overflow  out  N_BTN  sticky: a press arrived while that button was already pending
ovf_clr  in  1  one-cycle pulse that clears all overflow bits
tick  out  1  one-cycle sample strobe, exported for reuse

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - Tick counter = 0, debounced states = 0, stable counters = 0, round-robin pointer = 0, FSM = IDLE.
- Tick:
  - Counter runs 0..TICK_DIV-1 on every clk.
  - tick = 1 for exactly the cycle in which the counter equals TICK_DIV-1; the counter then wraps to 0.
- Synchronizer: each btn_in bit passes through a 2-flop synchronizer on clk. Latency is 2 cycles.
- Debounce, per channel, evaluated only on tick:
  - If sample == state, cnt = 0.
  - Otherwise cnt++. When cnt reaches STABLE_SAMPLES, state = sample and cnt = 0.
  - Glitches shorter than STABLE_SAMPLES ticks never change state.
- Press event: a one-cycle pulse on a 0->1 transition of the debounced state. Releases generate no event.
- Pending:
  - A press sets pending[i].
  - A grant of i (evt_valid && evt_ready && evt_id == i) clears pending[i].
  - Press while pending[i] = 1 and no grant that cycle: overflow[i] = 1, pending stays 1.
  - Press and grant of i in the same cycle: pending stays 1, no overflow.
- Overflow:
  - ovf_clr zeroes all bits.
  - If a new overflow and ovf_clr occur in the same cycle, the set wins for that bit.
- Arbiter FSM, states IDLE and OFFER:
  - IDLE: if pending != 0, register evt_id = first set bit searching upward from ptr (wrapping), set evt_valid = 1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: evt_valid and evt_id are held stable while evt_ready = 0 (no retraction). On evt_ready = 1: grant, ptr = (evt_id+1) mod N_BTN, evt_valid = 0, go to IDLE.
  - Maximum throughput: one event per 2 cycles.
- Reset mid-OFFER: the event is dropped and pending is cleared, with no other side effects.

Decomposition:
- Shared package holds:
  - The arbiter state enum (IDLE, OFFER).
  - The BTN_ID_W = clog2(N_BTN) width function/constant.
- One sub-module, btn_debounce_ch: synchronizer, stable counter, debounced state and press pulse for one channel, with tick as an input.
- btn_event_sched instantiates N_BTN copies of btn_debounce_ch and owns the tick counter, pending/overflow flags and arbiter.

Test Plan:
- Reset/tick, with TICK_DIV=4:
  - Stimulus: assert rst_n = 0 mid-run, then release.
  - Required: all outputs are 0 during reset; after release, tick pulses on cycles 3, 7, 11, ... and is never 2 cycles wide.
- Clean press, with TICK_DIV=4, STABLE_SAMPLES=2, evt_ready tied 1:
  - Stimulus: btn_in[2] rises and holds.
  - Required: exactly one offer with evt_id = 2, on the cycle after the second qualifying tick sets pending[2]. pending[2] returns to 0 after the grant. Releasing the button produces no event.
- Bounce rejection:
  - Stimulus: btn_in[0] toggles every 3 cycles for 40 cycles, with TICK_DIV=4, STABLE_SAMPLES=2.
  - Required: no press event, pending = 0, evt_valid never asserts.
- Round-robin, with evt_ready held 0:
  - Stimulus: buttons 0, 1 and 3 press simultaneously; then evt_ready pulses 1 once per offer.
  - Required: evt_id stays 0 and evt_valid stays 1 while evt_ready = 0. Grant order is 0, 1, 3. The next simultaneous press of 0 and 3 is granted in order 0, 3, since ptr wraps from 3+1 to 0.
- Overflow:
  - Stimulus: press button 1, release, press again while evt_ready = 0.
  - Required: overflow[1] = 1 while pending[1] stays 1. Pulsing ovf_clr clears overflow[1]. A further overflow of 1 in the same cycle as ovf_clr leaves overflow[1] = 1.
- Reset mid-offer:
  - Stimulus: evt_valid = 1 with evt_id = 2, then rst_n = 0 for 1 cycle.
  - Required: evt_valid, pending and overflow are 0 immediately (asynchronous). No event is re-offered after release until a new press.
